// File: rtl/pulse_cmd_ctrl_if.sv
// UART byte-side bundle for pulse_cmd_ctrl: receive strobe/byte/error, transmit handshake
// and the UART reset pulse. The slave modport is the command controller, the master the UART.
interface pulse_cmd_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_error;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       uart_rst;

    modport master (
        output rx_valid, rx_byte, rx_error, tx_ready,
        input  tx_valid, tx_byte, uart_rst
    );

    modport slave (
        input  rx_valid, rx_byte, rx_error, tx_ready,
        output tx_valid, tx_byte, uart_rst
    );
endinterface

// File: rtl/pulse_cmd_ctrl.sv
// Command sequencer: assembles CR/NL frames from the UART, decodes them into pulse_logic config
// writes and answers with one byte. Define PULSE_CMD_TIMEOUT_EN to add the idle-timeout discard.
module pulse_cmd_ctrl #(
    parameter int BYTES      = 16,
    parameter int COUNT_BITS = 32,
    parameter int CH_LOG2    = 3,
    parameter int ED_MAX     = 32,
    parameter int TIMEOUT    = 50_000_000,
    localparam int CH_MAX    = 1 << CH_LOG2,
    localparam int ED_BITS   = 2 * COUNT_BITS + CH_LOG2 + 1,
    localparam int AW        = $clog2(ED_MAX)
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    pulse_cmd_ctrl_if.slave       uart,
    output logic [CH_MAX-1:0]     state0,
    output logic [COUNT_BITS-1:0] period,
    output logic [COUNT_BITS-1:0] outer_period,
    output logic                  ed_we,
    output logic [AW-1:0]         ed_addr,
    output logic [ED_BITS-1:0]    ed_data,
    output logic                  logic_reset
);
    localparam int PW = $clog2(BYTES);
    localparam int CW = PW + 1;

    localparam logic [7:0] OP_STATE0 = 8'd1;
    localparam logic [7:0] OP_PER    = 8'd2;
    localparam logic [7:0] OP_OUTER  = 8'd3;
    localparam logic [7:0] OP_ED     = 8'd4;
    localparam logic [7:0] OP_CLEAR  = 8'd5;
    localparam logic [7:0] OP_PRINT  = 8'd6;
    localparam logic [7:0] NAK       = 8'h15;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_NL   = 8'h0A;

    typedef enum logic [2:0] {RECV, EXEC, CLEAR, RST, RESP} state_t;

    state_t                state_q;
    logic [7:0]            frame_q [BYTES];
    logic [CW-1:0]         cnt_q;
    logic [7:0]            last_q;
    logic [7:0]            tx_byte_q;
    logic                  uart_rst_q;
    logic                  is_term;
    logic                  ed_ok;
    logic                  tmo_fire;
    logic                  discard;
    logic                  store;
    logic                  clear_frame;
    logic [COUNT_BITS-1:0] count_field;
    logic [ED_BITS-1:0]    edge_field;

    assign uart.tx_byte  = tx_byte_q;
    assign uart.uart_rst = uart_rst_q;
    // Combinational so the strobe can never appear while the transmitter is busy.
    assign uart.tx_valid = (state_q == RESP) && uart.tx_ready;

    // Little-endian fields: the byte right after the opcode/index carries the LSBs.
    always_comb begin
        count_field = '0;
        for (int unsigned b = 0; b < COUNT_BITS; b++) begin
            count_field[b] = frame_q[1 + b / 8][b % 8];
        end
        edge_field = '0;
        for (int unsigned b = 0; b < ED_BITS; b++) begin
            edge_field[b] = frame_q[2 + b / 8][b % 8];
        end
    end

    always_comb begin
        is_term     = uart.rx_valid && (last_q == CHAR_CR) && (uart.rx_byte == CHAR_NL);
        ed_ok       = (frame_q[0] == OP_ED) && (int'(frame_q[1]) < ED_MAX);
        discard     = 1'b0;
        if (state_q == RECV) begin
            if (uart.rx_error) begin
                discard = 1'b1;
            end else if (uart.rx_valid) begin
                discard = !is_term && (cnt_q == CW'(BYTES));
            end else begin
                discard = tmo_fire;
            end
        end
        store       = (state_q == RECV) && uart.rx_valid && !uart.rx_error && !is_term
                      && (cnt_q != CW'(BYTES));
        clear_frame = discard || ((state_q == RESP) && uart.tx_ready);
    end

`ifdef PULSE_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= TW'(TIMEOUT);
        end else if ((state_q == RECV) && uart.rx_valid) begin
            tmo_q <= TW'(TIMEOUT);
        end else if ((cnt_q != '0) && (tmo_q != '0)) begin
            tmo_q <= tmo_q - TW'(1);
        end
    end

    assign tmo_fire = (state_q == RECV) && (cnt_q != '0) && (tmo_q == '0);
`else
    // TIMEOUT only matters when the idle counter is built in; here it can never fire.
    assign tmo_fire = (TIMEOUT < 0);
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '{default: '0};
            cnt_q   <= '0;
            last_q  <= '0;
        end else if (clear_frame) begin
            frame_q <= '{default: '0};
            cnt_q   <= '0;
            last_q  <= '0;
        end else if (store) begin
            frame_q[cnt_q[PW-1:0]] <= uart.rx_byte;
            cnt_q                  <= cnt_q + CW'(1);
            last_q                 <= uart.rx_byte;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RECV;
            state0       <= '0;
            period       <= '0;
            outer_period <= COUNT_BITS'(1);
            ed_we        <= 1'b0;
            ed_addr      <= '0;
            ed_data      <= '0;
            logic_reset  <= 1'b0;
            tx_byte_q    <= '0;
            uart_rst_q   <= 1'b0;
        end else begin
            ed_we       <= 1'b0;
            logic_reset <= 1'b0;
            uart_rst_q  <= 1'b0;
            case (state_q)
                RECV: begin
                    if (discard) begin
                        uart_rst_q <= 1'b1;
                    end else if (is_term && !uart.rx_error) begin
                        state_q <= EXEC;
                        // Edge write is issued on the terminator edge so ed_we lands in EXEC.
                        if (ed_ok) begin
                            ed_we   <= 1'b1;
                            ed_addr <= frame_q[1][AW-1:0];
                            ed_data <= edge_field;
                        end
                    end
                end
                EXEC: begin
                    tx_byte_q <= frame_q[0];
                    case (frame_q[0])
                        OP_STATE0: state0       <= frame_q[1][CH_MAX-1:0];
                        OP_PER:    period       <= count_field;
                        OP_OUTER:  outer_period <= count_field;
                        OP_ED:     if (!ed_ok) tx_byte_q <= NAK;
                        OP_CLEAR, OP_PRINT: ;
                        default:   tx_byte_q <= NAK;
                    endcase
                    if (ed_ok) begin
                        logic_reset <= 1'b1;
                        state_q     <= RST;
                    end else if (frame_q[0] == OP_CLEAR) begin
                        ed_we   <= 1'b1;
                        ed_addr <= '0;
                        ed_data <= '0;
                        state_q <= CLEAR;
                    end else begin
                        state_q <= RESP;
                    end
                end
                CLEAR: begin
                    if (ed_addr == AW'(ED_MAX - 1)) begin
                        logic_reset <= 1'b1;
                        state_q     <= RST;
                    end else begin
                        ed_we   <= 1'b1;
                        ed_addr <= ed_addr + AW'(1);
                    end
                end
                RST: state_q <= RESP;
                RESP: if (uart.tx_ready) state_q <= RECV;
                default: state_q <= RECV;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// Scoreboard bench for pulse_cmd_ctrl: frame-level reference model feeds expectation queues,
// an independent negedge monitor pops and compares every DUT strobe.
module tb_pulse_cmd_ctrl;
    localparam int TMO = 100;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  resp;
        int          due;
        bit          exact;
        logic [7:0]  s0;
        logic [31:0] per;
        logic [31:0] outp;
    } rsp_t;
    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [67:0] data;
    } wr_t;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    int          cyc     = 0;
    int          total   = 0;
    int          bad     = 0;
    rsp_t        rq[$];
    wr_t         wq[$];
    int          lrq[$];
    int          urq[$];
    logic [7:0]  m_s0;
    logic [31:0] m_per;
    logic [31:0] m_out;

    logic [7:0]  state0;
    logic [31:0] period;
    logic [31:0] outer_period;
    logic        ed_we;
    logic [4:0]  ed_addr;
    logic [67:0] ed_data;
    logic        logic_reset;

    pulse_cmd_ctrl_if uif ();

    pulse_cmd_ctrl #(.TIMEOUT(TMO)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .uart         (uif.slave),
        .state0       (state0),
        .period       (period),
        .outer_period (outer_period),
        .ed_we        (ed_we),
        .ed_addr      (ed_addr),
        .ed_data      (ed_data),
        .logic_reset  (logic_reset)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: interpret a whole stored frame (opcode..CR) and queue its effects.
    task automatic expect_frame(input bq_t fr, input int n, input bit exact);
        logic [7:0]  b [16];
        logic [71:0] w;
        logic [7:0]  resp;
        int          lat;
        foreach (b[i]) b[i] = 8'h00;
        foreach (fr[i]) b[i] = fr[i];
        resp = b[0];
        lat  = 2;
        case (b[0])
            8'd1: m_s0  = b[1];
            8'd2: m_per = {b[4], b[3], b[2], b[1]};
            8'd3: m_out = {b[4], b[3], b[2], b[1]};
            8'd4: begin
                if (b[1] < 8'd32) begin
                    for (int k = 0; k < 9; k++) w[8*k +: 8] = b[2+k];
                    wq.push_back('{due: n + 1, addr: b[1][4:0], data: w[67:0]});
                    lrq.push_back(n + 2);
                    lat = 3;
                end else begin
                    resp = 8'h15;
                end
            end
            8'd5: begin
                for (int a = 0; a < 32; a++) wq.push_back('{due: n + 2 + a, addr: a[4:0], data: '0});
                lrq.push_back(n + 34);
                lat = 35;
            end
            8'd6: ;
            default: resp = 8'h15;
        endcase
        rq.push_back('{resp: resp, due: n + lat, exact: exact, s0: m_s0, per: m_per, outp: m_out});
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        uif.rx_byte  = v;
        uif.rx_valid = 1'b1;
        tick(1);
        uif.rx_valid = 1'b0;
    endtask

    task automatic pulse_rx_error();
        urq.push_back(cyc + 1);
        uif.rx_error = 1'b1;
        tick(1);
        uif.rx_error = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq.size() + wq.size() + lrq.size() + urq.size()) > 0 && t < 3000) begin
            tick(1);
            t++;
        end
        chk("drain_in_time", t < 3000, 1'b1);
        tick(2);
    endtask

    task automatic send_frame(input bq_t fr, input bit stall);
        if (stall) uif.tx_ready = 1'b0;
        foreach (fr[i]) begin
            send_byte(fr[i]);
            tick($urandom_range(0, 2));
        end
        expect_frame(fr, cyc, !stall);
        send_byte(8'h0A);
        if (stall) begin
            tick($urandom_range(1, 60));
            uif.tx_ready = 1'b1;
        end
        drain();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state0"}, state0, 8'h00);
        chk({tag, "_period"}, period, 32'd0);
        chk({tag, "_outer_period"}, outer_period, 32'd1);
        chk({tag, "_ed_addr"}, ed_addr, 5'd0);
        chk({tag, "_ed_data"}, ed_data, 68'd0);
        chk({tag, "_tx_byte"}, uif.tx_byte, 8'h00);
        chk({tag, "_strobes"}, {uif.tx_valid, ed_we, logic_reset, uif.uart_rst}, 4'b0000);
    endtask

    always @(negedge sys_clk) begin : monitor
        rsp_t r;
        wr_t  w;
        int   t;
        if (rst_n) begin
            if (uif.tx_valid) begin
                chk("tx_ready_at_tx_valid", uif.tx_ready, 1'b1);
                chk("tx_expected", rq.size() > 0, 1'b1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("tx_byte", uif.tx_byte, r.resp);
                    if (r.exact) chk("tx_cycle", cyc, r.due);
                    else         chk("tx_not_early", cyc >= r.due, 1'b1);
                    chk("state0", state0, r.s0);
                    chk("period", period, r.per);
                    chk("outer_period", outer_period, r.outp);
                end
            end
            if (ed_we) begin
                chk("ed_we_expected", wq.size() > 0, 1'b1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("ed_we_cycle", cyc, w.due);
                    chk("ed_addr", ed_addr, w.addr);
                    chk("ed_data", ed_data, w.data);
                end
            end
            if (logic_reset) begin
                chk("logic_reset_expected", lrq.size() > 0, 1'b1);
                if (lrq.size() > 0) begin
                    t = lrq.pop_front();
                    chk("logic_reset_cycle", cyc, t);
                end
            end
            if (uif.uart_rst) begin
                chk("uart_rst_expected", urq.size() > 0, 1'b1);
                if (urq.size() > 0) begin
                    t = urq.pop_front();
                    chk("uart_rst_cycle", cyc, t);
                end
            end
        end
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: got cycle %0d, required completion before it", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t fr;
        int  n;
        int  r;
        logic [7:0] op;
        logic [7:0] v;
        uif.rx_valid = 1'b0;
        uif.rx_byte  = 8'h00;
        uif.rx_error = 1'b0;
        uif.tx_ready = 1'b1;
        m_s0  = 8'h00;
        m_per = 32'd0;
        m_out = 32'd1;
        tick(3);
        check_reset("por");
        rst_n = 1'b1;
        tick(2);

        fr = '{8'h02, 8'h10, 8'h27, 8'h00, 8'h00, 8'h0D};
        send_frame(fr, 1'b0);

        fr = '{8'h04, 8'h03};
        repeat (9) fr.push_back(8'hFF);
        fr.push_back(8'h0D);
        send_frame(fr, 1'b0);

        fr = '{8'h04, 8'h20, 8'h12, 8'h34, 8'h0D};
        send_frame(fr, 1'b0);

        // CLEAR with the transmitter busy; bytes sent meanwhile must be ignored.
        uif.tx_ready = 1'b0;
        fr = '{8'h05, 8'h0D};
        foreach (fr[i]) send_byte(fr[i]);
        expect_frame(fr, cyc, 1'b0);
        send_byte(8'h0A);
        tick(4);
        send_byte(8'h01);
        send_byte(8'h33);
        tick(90);
        uif.tx_ready = 1'b1;
        drain();

        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        urq.push_back(cyc + 1);
        send_byte(8'h40);
        drain();
        fr = '{8'h01, 8'hA5, 8'h0D};
        send_frame(fr, 1'b0);

        fr = '{8'h02};
        for (int i = 0; i < 14; i++) fr.push_back(8'h11 + 8'(i));
        fr.push_back(8'h0D);
        send_frame(fr, 1'b0);

        fr = '{8'h0A, 8'h0D};
        send_frame(fr, 1'b0);

        send_byte(8'h03);
        send_byte(8'h55);
        pulse_rx_error();
        drain();
        fr = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0D};
        send_frame(fr, 1'b0);

        n = cyc;
        send_byte(8'h01);
`ifdef PULSE_CMD_TIMEOUT_EN
        urq.push_back(n + TMO + 2);
`endif
        tick(300);
        pulse_rx_error();
        drain();

        for (int f = 0; f < 50; f++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      op = 8'(r + 1);
            else if (r < 8) op = 8'd4;
            else            op = 8'($urandom_range(0, 255));
            fr = '{op};
            n = $urandom_range(0, 14);
            for (int i = 0; i < n; i++) begin
                v = 8'($urandom_range(0, 255));
                if (i == 0 && op == 8'd4 && $urandom_range(0, 3) != 0) v = 8'($urandom_range(0, 40));
                fr.push_back(v);
            end
            fr.push_back(8'h0D);
            for (int i = 1; i < fr.size(); i++) begin
                if (fr[i-1] == 8'h0D && fr[i] == 8'h0A) fr[i] = 8'h0B;
            end
            send_frame(fr, $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset in the middle of a CLEAR sweep.
        fr = '{8'h05, 8'h0D};
        foreach (fr[i]) send_byte(fr[i]);
        expect_frame(fr, cyc, 1'b1);
        send_byte(8'h0A);
        tick(10);
        rst_n = 1'b0;
        #1;
        rq.delete();
        wq.delete();
        lrq.delete();
        urq.delete();
        m_s0  = 8'h00;
        m_per = 32'd0;
        m_out = 32'd1;
        check_reset("mid_clear");
        tick(1);
        rst_n = 1'b1;
        tick(60);
        fr = '{8'h01, 8'h3C, 8'h0D};
        send_frame(fr, 1'b0);

        chk("queues_empty", rq.size() + wq.size() + lrq.size() + urq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
